// File: rtl/uart_dev_pkg.sv
// Shared constants for the memory-mapped UART transmitter:
// register indices, STATUS/CTRL bit positions and FSM state codes.
package uart_dev_pkg;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;
  localparam logic [1:0] REG_DIV    = 2'd3;

  localparam int ST_CNT_LSB = 0;
  localparam int ST_EMPTY   = 4;
  localparam int ST_FULL    = 5;
  localparam int ST_BUSY    = 6;
  localparam int ST_DONE    = 7;
  localparam int ST_OVF     = 8;

  localparam int CTRL_IE  = 0;
  localparam int CTRL_EN  = 1;
  localparam int CTRL_ODD = 2;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

endpackage

// File: rtl/tx_fifo.sv
// Synchronous FIFO for the UART TX queue; push while full is accepted
// only when a pop happens the same cycle. Ports: i_push/i_pop/i_din in, o_dout/o_full/o_empty/o_count out.
module tx_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic [W-1:0]  i_din,
  output logic [W-1:0]  o_dout,
  output logic          o_full,
  output logic          o_empty,
  output logic [AW:0]   o_count
);

  localparam logic [AW-1:0] PTR_ONE  = 1;
  localparam logic [AW:0]   CNT_ONE  = 1;
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wp;
  logic [AW-1:0] r_rp;
  logic [AW:0]   r_cnt;
  logic          w_wr;
  logic          w_rd;

  assign o_full  = (r_cnt == CNT_FULL);
  assign o_empty = (r_cnt == '0);
  assign o_count = r_cnt;
  assign o_dout  = r_mem[r_rp];

  assign w_wr = i_push && (!o_full || i_pop);
  assign w_rd = i_pop && !o_empty;

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wp] <= i_din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_wr) r_wp <= r_wp + PTR_ONE;
      if (w_rd) r_rp <= r_rp + PTR_ONE;
      case ({w_wr, w_rd})
        2'b10:   r_cnt <= r_cnt + CNT_ONE;
        2'b01:   r_cnt <= r_cnt - CNT_ONE;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_device.sv
// Memory-mapped 8N1 UART transmitter with TX FIFO and drain IRQ.
// Ports: clk, rst (async active-low), we/ADDr_in/Data_in/Data_out bridge
// access, IRQ level to CP0, txd serial out. Define UART_TX_PARITY_EN for
// an extra parity bit (even, or odd when CTRL[2] is set).
module uart_tx_device
  import uart_dev_pkg::*;
#(
  parameter int FIFO_DEPTH  = 8,
  parameter int DIV_W       = 16,
  parameter int DEFAULT_DIV = 434
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [1:0]  ADDr_in,
  input  logic [31:0] Data_in,
  output logic [31:0] Data_out,
  output logic        IRQ,
  output logic        txd
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [DIV_W-1:0] DIV_ONE = 1;

  logic             r_ie;
  logic             r_en;
  logic [DIV_W-1:0] r_div;
  logic             r_done;
  logic             r_ovf;
  logic             r_irq;
  logic [2:0]       r_state;
  logic [DIV_W-1:0] r_cnt;
  logic [2:0]       r_idx;
  logic [7:0]       r_shift;
  logic             r_txd;

  logic             w_push;
  logic             w_pop;
  logic             w_full;
  logic             w_empty;
  logic [AW:0]      w_count;
  logic [7:0]       w_dout;
  logic             w_tick;
  logic             w_more;
  logic             w_busy;
  logic             w_clr;
  logic             w_ie_nxt;
  logic             w_done_nxt;
  logic             w_ovf_nxt;
  logic [DIV_W-1:0] w_divm1;
  logic             w_odd;
  logic             w_unused;

  assign w_unused = ^Data_in;

  tx_fifo #(.DEPTH(FIFO_DEPTH), .W(8)) u_fifo (
    .clk     (clk),
    .rst_n   (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_din   (Data_in[7:0]),
    .o_dout  (w_dout),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  assign w_push  = we && (ADDr_in == REG_DATA);
  assign w_clr   = we && (ADDr_in == REG_STATUS);
  assign w_tick  = (r_cnt == '0);
  assign w_more  = r_en && !w_empty;
  assign w_busy  = (r_state != S_IDLE);
  // Divisor 0 is treated as 1: every state lasts at least one clock.
  assign w_divm1 = (r_div == '0) ? '0 : r_div - DIV_ONE;

  assign w_pop = w_more &&
    ((r_state == S_IDLE) || ((r_state == S_STOP) && w_tick));

  // Set beats clear when both land on the same edge.
  assign w_ie_nxt   = (we && ADDr_in == REG_CTRL) ? Data_in[CTRL_IE] : r_ie;
  assign w_done_nxt = ((r_state == S_STOP) && w_tick && w_empty)
                    | (r_done & ~w_clr);
  assign w_ovf_nxt  = (w_push && w_full && !w_pop) | (r_ovf & ~w_clr);

`ifdef UART_TX_PARITY_EN
  logic r_odd;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_odd <= 1'b0;
    else if (we && ADDr_in == REG_CTRL) r_odd <= Data_in[CTRL_ODD];
  end
  assign w_odd = r_odd;
`else
  assign w_odd = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ie   <= 1'b0;
      r_en   <= 1'b0;
      r_div  <= DIV_W'(DEFAULT_DIV);
      r_done <= 1'b0;
      r_ovf  <= 1'b0;
      r_irq  <= 1'b0;
    end else begin
      if (we && ADDr_in == REG_CTRL) begin
        r_ie <= Data_in[CTRL_IE];
        r_en <= Data_in[CTRL_EN];
      end
      if (we && ADDr_in == REG_DIV) r_div <= Data_in[DIV_W-1:0];
      r_done <= w_done_nxt;
      r_ovf  <= w_ovf_nxt;
      r_irq  <= w_ie_nxt & w_done_nxt;
    end
  end

  // The bit counter reloads from r_div only at bit boundaries, so a DIV
  // write never stretches or shortens the bit already on the line.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_txd   <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_more) begin
            r_state <= S_START;
            r_shift <= w_dout;
            r_txd   <= 1'b0;
            r_cnt   <= w_divm1;
          end
        end
        S_START: begin
          if (w_tick) begin
            r_state <= S_DATA;
            r_idx   <= '0;
            r_txd   <= r_shift[0];
            r_cnt   <= w_divm1;
          end else begin
            r_cnt <= r_cnt - DIV_ONE;
          end
        end
        S_DATA: begin
          if (w_tick) begin
            r_cnt <= w_divm1;
            if (r_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              r_state <= S_PARITY;
              r_txd   <= (^r_shift) ^ w_odd;
`else
              r_state <= S_STOP;
              r_txd   <= 1'b1;
`endif
            end else begin
              r_idx <= r_idx + 3'd1;
              r_txd <= r_shift[r_idx + 3'd1];
            end
          end else begin
            r_cnt <= r_cnt - DIV_ONE;
          end
        end
`ifdef UART_TX_PARITY_EN
        S_PARITY: begin
          if (w_tick) begin
            r_state <= S_STOP;
            r_txd   <= 1'b1;
            r_cnt   <= w_divm1;
          end else begin
            r_cnt <= r_cnt - DIV_ONE;
          end
        end
`endif
        S_STOP: begin
          if (w_tick) begin
            if (w_more) begin
              r_state <= S_START;
              r_shift <= w_dout;
              r_txd   <= 1'b0;
              r_cnt   <= w_divm1;
            end else begin
              r_state <= S_IDLE;
            end
          end else begin
            r_cnt <= r_cnt - DIV_ONE;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_txd   <= 1'b1;
        end
      endcase
    end
  end

  assign txd = r_txd;
  assign IRQ = r_irq;

  always_comb begin
    Data_out = '0;
    unique case (ADDr_in)
      REG_DATA: Data_out = '0;
      REG_STATUS: begin
        Data_out[ST_CNT_LSB +: 4] = 4'(w_count);
        Data_out[ST_EMPTY]        = w_empty;
        Data_out[ST_FULL]         = w_full;
        Data_out[ST_BUSY]         = w_busy;
        Data_out[ST_DONE]         = r_done;
        Data_out[ST_OVF]          = r_ovf;
      end
      REG_CTRL: begin
        Data_out[CTRL_IE]  = r_ie;
        Data_out[CTRL_EN]  = r_en;
        Data_out[CTRL_ODD] = w_odd;
      end
      REG_DIV: Data_out = 32'(r_div);
      default: Data_out = '0;
    endcase
  end

endmodule
